alu_branch_unit: RTL and testbench

- Execute-stage datapath block of the multicycle MIPS-style CPU.
- Decodes the ALU control code from ALUOp plus instruction fields, then performs the 32-bit ALU operation and produces the zero flag.
- Generates the conditional-PC-write term, PCWrCond AND Zero.
- Holds the ALUOut pipeline register that feeds the PC-source and write-back muxes.

---
 rtl/alu_branch_unit.sv | 99 +++++++++
 tb/tb_alu_branch_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_branch_unit.sv
// Execute-stage ALU for the multicycle MIPS-style CPU: control decode, 32-bit ALU,
// zero flag, conditional-PC-write term, and the ALUOut register.
module alu_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [31:0]      Inst,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] AluA,
  input  logic [WIDTH-1:0] AluB,
  input  logic             PCWrCond,
  output logic [2:0]       AluCtrl,
  output logic [WIDTH-1:0] AluC,
  output logic             AluZ,
  output logic             AO,
  output logic [WIDTH-1:0] AluOut
);

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_XOR  = 3'b011;
  localparam logic [2:0] CTRL_NOR  = 3'b100;
  localparam logic [2:0] CTRL_SLTU = 3'b101;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_SLT  = 3'b111;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_inst;

  assign opcode      = Inst[31:26];
  assign funct       = Inst[5:0];
  // Register/immediate fields are decoded elsewhere in the CPU.
  assign unused_inst = ^Inst[25:6];

  always_comb begin
    AluCtrl = CTRL_ADD;
    unique case (ALUOp)
      2'b00: AluCtrl = CTRL_ADD;
      2'b01: AluCtrl = CTRL_SUB;
      2'b10: begin
        case (funct)
          6'b100000: AluCtrl = CTRL_ADD;
          6'b100010: AluCtrl = CTRL_SUB;
          6'b100100: AluCtrl = CTRL_AND;
          6'b100101: AluCtrl = CTRL_OR;
          6'b100110: AluCtrl = CTRL_XOR;
          6'b100111: AluCtrl = CTRL_NOR;
          6'b101010: AluCtrl = CTRL_SLT;
          6'b101011: AluCtrl = CTRL_SLTU;
          default:   AluCtrl = CTRL_ADD;
        endcase
      end
      2'b11: begin
        case (opcode)
          6'b001100: AluCtrl = CTRL_AND;
          6'b001101: AluCtrl = CTRL_OR;
          6'b001110: AluCtrl = CTRL_XOR;
          6'b001010: AluCtrl = CTRL_SLT;
          6'b001011: AluCtrl = CTRL_SLTU;
          default:   AluCtrl = CTRL_ADD;
        endcase
      end
      default: AluCtrl = CTRL_ADD;
    endcase
  end

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(AluA) < $signed(AluB);
  assign lt_unsigned = AluA < AluB;

  always_comb begin
    AluC = '0;
    unique case (AluCtrl)
      CTRL_AND:  AluC = AluA & AluB;
      CTRL_OR:   AluC = AluA | AluB;
      CTRL_ADD:  AluC = AluA + AluB;
      CTRL_SUB:  AluC = AluA - AluB;
      CTRL_XOR:  AluC = AluA ^ AluB;
      CTRL_NOR:  AluC = ~(AluA | AluB);
      CTRL_SLT:  AluC = {{(WIDTH-1){1'b0}}, lt_signed};
      CTRL_SLTU: AluC = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default:   AluC = '0;
    endcase
  end

  assign AluZ = (AluC == '0);
  assign AO   = PCWrCond & AluZ;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) AluOut <= '0;
    else          AluOut <= AluC;
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed-vector bench: stimulus pushes expected results into a queue, a monitor
// pops and checks after each rising edge.
module tb_alu_branch_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] Inst = '0;
  logic [1:0]  ALUOp = '0;
  logic [31:0] AluA = '0;
  logic [31:0] AluB = '0;
  logic        PCWrCond = 1'b0;
  logic [2:0]  AluCtrl;
  logic [31:0] AluC;
  logic        AluZ;
  logic        AO;
  logic [31:0] AluOut;

  alu_branch_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Inst(Inst), .ALUOp(ALUOp),
    .AluA(AluA), .AluB(AluB), .PCWrCond(PCWrCond),
    .AluCtrl(AluCtrl), .AluC(AluC), .AluZ(AluZ), .AO(AO), .AluOut(AluOut)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] c;
    logic        z;
    logic        ao;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h0, fn};
  endfunction

  task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [1:0] aop, input logic [31:0] a, input logic [31:0] b,
                       input logic pcw, input logic [2:0] ectrl, input logic [31:0] ec,
                       input logic ez, input logic eao);
    exp_t e;
    @(negedge Clock);
    Inst = mk_inst(op, fn);
    ALUOp = aop;
    AluA = a;
    AluB = b;
    PCWrCond = pcw;
    e.name = name; e.ctrl = ectrl; e.c = ec; e.z = ez; e.ao = eao;
    q.push_back(e);
  endtask

  // Monitor: inputs are held from the previous falling edge, so just after the
  // rising edge both the combinational outputs and AluOut reflect the vector.
  always begin
    exp_t e;
    @(posedge Clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".ctrl"}, {29'h0, AluCtrl}, {29'h0, e.ctrl});
      chk({e.name, ".c"}, AluC, e.c);
      chk({e.name, ".z"}, {31'h0, AluZ}, {31'h0, e.z});
      chk({e.name, ".ao"}, {31'h0, AO}, {31'h0, e.ao});
      chk({e.name, ".aluout"}, AluOut, e.c);
    end
  end

  initial begin
    // Reset behaviour: load a nonzero value, then assert reset mid-cycle.
    @(negedge Clock);
    chk("rst_init_aluout", AluOut, 32'h0);
    Reset_n = 1'b1;
    AluA = 32'd5; AluB = 32'd7; ALUOp = 2'b00;
    @(posedge Clock); #1;
    chk("pre_rst_aluout", AluOut, 32'd12);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_aluout", AluOut, 32'h0);
    chk("rst_comb_tracks", AluC, 32'd12);
    @(posedge Clock); #1;
    chk("rst_hold_aluout", AluOut, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    apply("add5_7", 6'h00, 6'h00, 2'b00, 32'd5, 32'd7, 1'b0, 3'b010, 32'd12, 1'b0, 1'b0);
    // Subtract / branch
    apply("beq_eq", 6'h04, 6'h00, 2'b01, 32'h1234, 32'h1234, 1'b1, 3'b110, 32'h0, 1'b1, 1'b1);
    apply("beq_ne", 6'h04, 6'h00, 2'b01, 32'h1234, 32'h1235, 1'b1, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0);
    apply("beq_nopcw", 6'h04, 6'h00, 2'b01, 32'h1234, 32'h1234, 1'b0, 3'b110, 32'h0, 1'b1, 1'b0);
    // R-type sweep
    apply("r_and", 6'h00, 6'b100100, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b000, 32'h00F000F0, 1'b0, 1'b0);
    apply("r_or", 6'h00, 6'b100101, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0);
    apply("r_xor", 6'h00, 6'b100110, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b011, 32'hFF00FF00, 1'b0, 1'b0);
    apply("r_nor", 6'h00, 6'b100111, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b100, 32'h000F000F, 1'b0, 1'b0);
    apply("r_unk", 6'h00, 6'b000000, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b010, 32'h00E100E0, 1'b0, 1'b0);
    apply("r_add", 6'h00, 6'b100000, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b010, 32'h00E100E0, 1'b0, 1'b0);
    apply("r_sub", 6'h00, 6'b100010, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b110, 32'hE100E100, 1'b0, 1'b0);
    // Compares
    apply("r_slt", 6'h00, 6'b101010, 2'b10, 32'hFFFFFFFF, 32'd1, 1'b0, 3'b111, 32'd1, 1'b0, 1'b0);
    apply("r_sltu", 6'h00, 6'b101011, 2'b10, 32'hFFFFFFFF, 32'd1, 1'b1, 3'b101, 32'd0, 1'b1, 1'b1);
    apply("slti_eq", 6'b001010, 6'h00, 2'b11, 32'd3, 32'd3, 1'b0, 3'b111, 32'd0, 1'b1, 1'b0);
    // Wrap-around
    apply("add_wrap", 6'h00, 6'h00, 2'b00, 32'hFFFFFFFF, 32'd1, 1'b0, 3'b010, 32'h0, 1'b1, 1'b0);
    apply("sub_wrap", 6'h00, 6'h00, 2'b01, 32'h0, 32'd1, 1'b0, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0);
    // Immediate decode; funct bits set to something R-type-looking to prove they are ignored
    apply("andi", 6'b001100, 6'b100010, 2'b11, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b000, 32'h00F000F0, 1'b0, 1'b0);
    apply("ori", 6'b001101, 6'b100100, 2'b11, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0);
    apply("xori", 6'b001110, 6'b100100, 2'b11, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b011, 32'hFF00FF00, 1'b0, 1'b0);
    apply("sltiu", 6'b001011, 6'b100100, 2'b11, 32'd1, 32'd2, 1'b0, 3'b101, 32'd1, 1'b0, 1'b0);
    apply("sltiu_big", 6'b001011, 6'h00, 2'b11, 32'hFFFFFFFF, 32'd1, 1'b0, 3'b101, 32'd0, 1'b1, 1'b0);
    apply("imm_unk", 6'b100011, 6'b100010, 2'b11, 32'd100, 32'd4, 1'b0, 3'b010, 32'd104, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clock);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
